seg_scan_ctrl: RTL and testbench

Display scan controller that shares the board's single seven-segment cathode bus (seg, dp) among up to eight digits by time-multiplexing the anode lines. It holds a double-buffered register file of hex digits and decimal points, loaded by a write port and made visible by a commit handshake only at frame boundaries, so no frame ever shows a partial update. It inserts an all-off blanking interval between digit slots to suppress ghosting. It sits between the keypad/datapath logic and the board's an/seg/dp pins, replacing the single-digit hard-wired display path.

---
 rtl/seg_scan_ctrl_if.sv | 13 +
 rtl/seg_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// Write/commit port of the seven-segment scan controller.
// master: keypad/datapath side; slave: seg_scan_ctrl.
interface seg_scan_ctrl_if;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;
  logic       commit;
  logic       busy;

  modport master (output wr_en, wr_addr, wr_data, wr_dp, commit, input busy);
  modport slave  (input wr_en, wr_addr, wr_data, wr_dp, commit, output busy);
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed seven-segment scan controller.
// Double-buffered digit file (back written by the port, front displayed),
// with back->front transfers only at frame boundaries.
// Optional macro SEG_SCAN_BLANK_EN: when defined, each slot starts with
// BLANK_CYCLES all-off cycles; when undefined, every cycle is SHOW.
module seg_scan_ctrl #(
  parameter int DIGITS       = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic              clk100MHz,
  input  logic              rst_n,
  seg_scan_ctrl_if.slave    bus,
  input  logic [DIGITS-1:0] digit_en,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(DIGITS - 1);

  typedef struct packed {
    logic       dp;
    logic [3:0] hex;
  } digit_t;

  logic [CW-1:0] cnt;
  logic [SW-1:0] slot;
  logic          pending;
  digit_t [DIGITS-1:0] back, front;

  logic slot_end, boundary, show, wr_ok;
  logic [DIGITS-1:0] slot_sel, an_show;

  assign slot_end = (cnt == CNT_LAST);
  assign boundary = slot_end && (slot == SLOT_LAST);
  assign wr_ok    = bus.wr_en && (int'(bus.wr_addr) < DIGITS);
  assign slot_sel = DIGITS'(1) << slot;
  assign an_show  = ~(slot_sel & digit_en);
  assign bus.busy = pending;

  // Low-asserted {g,f,e,d,c,b,a} glyphs for 0-F.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Slot timer and slot index; frame length never depends on digit_en.
  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      slot <= '0;
    end else if (slot_end) begin
      cnt  <= '0;
      slot <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef SEG_SCAN_BLANK_EN
  localparam logic [0:0] PH_BLANK = 1'b0;
  localparam logic [0:0] PH_SHOW  = 1'b1;
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [0:0] PH_START = (BLANK_CYCLES == 0) ? PH_SHOW : PH_BLANK;

  logic [0:0] phase;

  // Phase: BLANK at the start of every slot, SHOW once cnt reaches BLANK_CYCLES.
  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n)
      phase <= PH_START;
    else if (slot_end)
      phase <= PH_START;
    else if (CW'(cnt + 1'b1) == BLANK_END)
      phase <= PH_SHOW;
  end

  assign show = (phase == PH_SHOW);
`else
  assign show = 1'b1;
`endif

  // Registered pin drives: one cycle behind the cnt/slot/phase state.
  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      an         <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (show) begin
        an  <= an_show;
        seg <= hex7(front[slot].hex);
        dp  <= ~front[slot].dp;
      end else begin
        an  <= '1;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end
    end
  end

  // Back buffer writes, commit tracking and boundary transfer (front takes pre-edge back).
  always_ff @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      back    <= '0;
      front   <= '0;
      pending <= 1'b0;
    end else begin
      if (wr_ok)
        back[bus.wr_addr[SW-1:0]] <= '{dp: bus.wr_dp, hex: bus.wr_data};
      if (boundary) begin
        if (pending || bus.commit)
          front <= back;
        pending <= 1'b0;
      end else if (bus.commit) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
// Works with or without SEG_SCAN_BLANK_EN defined.
module tb_seg_scan_ctrl;
  localparam int D  = 4;
  localparam int RD = 8;
  localparam int BL = 2;
`ifdef SEG_SCAN_BLANK_EN
  localparam int BLE = BL;
`else
  localparam int BLE = 0;
`endif
  localparam int FR = D * RD;

  logic clk100MHz = 1'b0;
  logic rst_n = 1'b1;
  logic [D-1:0] den;
  logic [D-1:0] an;
  logic [6:0] seg;
  logic dp, frame_done;

  seg_scan_ctrl_if bus();

  seg_scan_ctrl #(.DIGITS(D), .REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
    .clk100MHz(clk100MHz), .rst_n(rst_n), .bus(bus), .digit_en(den),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done));

  always #5 clk100MHz = ~clk100MHz;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  // ---------------- behavioural model ----------------
  // Absolute cycle count since reset gives cnt/slot by plain arithmetic.
  int s;
  logic [4:0] m_back [D];
  logic [4:0] m_front [D];
  logic m_pend;
  logic [D-1:0] exp_an;
  logic [6:0] exp_seg;
  logic exp_dp, exp_fd;

  // Active-high segment patterns, inverted for the low-asserted pins.
  function automatic logic [6:0] glyph(input logic [3:0] h);
    logic [6:0] on;
    case (h)
      4'h0: on = 7'h3F; 4'h1: on = 7'h06; 4'h2: on = 7'h5B; 4'h3: on = 7'h4F;
      4'h4: on = 7'h66; 4'h5: on = 7'h6D; 4'h6: on = 7'h7D; 4'h7: on = 7'h07;
      4'h8: on = 7'h7F; 4'h9: on = 7'h6F; 4'hA: on = 7'h77; 4'hB: on = 7'h7C;
      4'hC: on = 7'h39; 4'hD: on = 7'h5E; 4'hE: on = 7'h79; default: on = 7'h71;
    endcase
    return ~on;
  endfunction

  function automatic logic [D-1:0] an_of(input int sl, input logic [D-1:0] en);
    logic [D-1:0] a;
    a = '1;
    a[sl] = ~en[sl];
    return a;
  endfunction

  always @(posedge clk100MHz or negedge rst_n) begin
    if (!rst_n) begin
      s <= 0;
      m_pend <= 1'b0;
      for (int i = 0; i < D; i++) begin
        m_back[i] <= '0;
        m_front[i] <= '0;
      end
      exp_an <= '1; exp_seg <= 7'h7F; exp_dp <= 1'b1; exp_fd <= 1'b0;
    end else begin
      exp_fd <= ((s % FR) == FR - 1);
      if ((s % RD) < BLE) begin
        exp_an <= '1; exp_seg <= 7'h7F; exp_dp <= 1'b1;
      end else begin
        exp_an  <= an_of((s / RD) % D, den);
        exp_seg <= glyph(m_front[(s / RD) % D][3:0]);
        exp_dp  <= ~m_front[(s / RD) % D][4];
      end
      if (bus.wr_en && int'(bus.wr_addr) < D)
        m_back[bus.wr_addr] <= {bus.wr_dp, bus.wr_data};
      if ((s % FR) == FR - 1) begin
        if (m_pend || bus.commit) m_front <= m_back;
        m_pend <= 1'b0;
      end else if (bus.commit) begin
        m_pend <= 1'b1;
      end
      s <= s + 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk100MHz);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] d, input logic p);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_dp = p;
    tick();
    bus.wr_en = 1'b0; bus.wr_dp = 1'b0;
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    while (!frame_done && n < 2 * FR) begin
      tick();
      n++;
    end
    if (!frame_done) begin
      checks++;
      failures++;
      $display("FAIL wait_fd: frame_done not seen within %0d cycles", 2 * FR);
    end
  endtask

  logic [6:0] g1234 [4];
  int lo [D];
  int fd_n, fd_last, all_off;

  initial begin
    g1234[0] = 7'b1111001; g1234[1] = 7'b0100100;
    g1234[2] = 7'b0110000; g1234[3] = 7'b0011001;
    den = '1;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.wr_dp = 0; bus.commit = 0;

    // Per-cycle comparison against the model.
    fork
      forever begin
        @(negedge clk100MHz);
        if (chk_on) begin
          checks++;
          if ({an, seg, dp, frame_done, bus.busy} !==
              {exp_an, exp_seg, exp_dp, exp_fd, m_pend}) begin
            failures++;
            $display("FAIL model_cmp s=%0d: an=%b seg=%b dp=%b fd=%b busy=%b expected an=%b seg=%b dp=%b fd=%b busy=%b",
                     s, an, seg, dp, frame_done, bus.busy, exp_an, exp_seg, exp_dp, exp_fd, m_pend);
          end
        end
      end
    join_none

    #2 rst_n = 1'b0;
    tick_n(2);
    chk_on = 1'b1;
    chk("reset_an", 32'(an), 32'hF);
    chk("reset_seg", 32'(seg), 32'h7F);
    rst_n = 1'b1;

    // First anode after release.
`ifdef SEG_SCAN_BLANK_EN
    tick_n(BLE);
    chk("blank_before_first_an", 32'(an), 32'hF);
    tick();
`else
    tick_n(BLE + 1);
`endif
    chk("first_an", 32'(an), 32'b1110);
    chk("first_seg_glyph0", 32'(seg), 32'b1000000);

    // Commit -> busy one cycle later, then async reset mid-SHOW clears it.
    bus.commit = 1'b1; tick(); bus.commit = 1'b0;
    chk("busy_after_commit", 32'(bus.busy), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_an", 32'(an), 32'hF);
    chk("async_rst_seg", 32'(seg), 32'h7F);
    chk("async_rst_dp", 32'(dp), 32'd1);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    tick_n(2);
    rst_n = 1'b1;

    // Load 1,2,3,4 (dp on digit 2) and commit.
    wr(3'd0, 4'h1, 1'b0); wr(3'd1, 4'h2, 1'b0);
    wr(3'd2, 4'h3, 1'b1); wr(3'd3, 4'h4, 1'b0);
    bus.commit = 1'b1; tick(); bus.commit = 1'b0;
    chk("busy_pending", 32'(bus.busy), 32'd1);
    wait_fd();
    chk("busy_clear_at_fd", 32'(bus.busy), 32'd0);
`ifdef SEG_SCAN_BLANK_EN
    tick();
    chk("slot0_blank_an", 32'(an), 32'hF);
    tick_n(BLE);
`else
    tick_n(BLE + 1);
`endif
    for (int j = 0; j < D; j++) begin
      if (j > 0) tick_n(RD);
      chk("frame_seg", 32'(seg), 32'(g1234[j]));
      chk("frame_dp", 32'(dp), (j == 2) ? 32'd0 : 32'd1);
    end

    // Writes without commit, plus an out-of-range address: display unchanged.
    wr(3'd0, 4'h5, 1'b0); wr(3'd1, 4'h6, 1'b0);
    wr(3'd2, 4'h7, 1'b0); wr(3'd3, 4'h8, 1'b1);
    wr(3'd5, 4'hF, 1'b1);
    tick_n(3 * FR);
    wait_fd();
    tick_n(BLE + 1);
    chk("no_commit_slot0", 32'(seg), 32'b1111001);

    // digit_en mask: disabled digits never light, frame period unchanged.
    den = 4'b1010;
    wait_fd();
    for (int i = 0; i < D; i++) lo[i] = 0;
    fd_n = 0; fd_last = 0;
    for (int t = 1; t <= FR; t++) begin
      tick();
      for (int i = 0; i < D; i++) if (!an[i]) lo[i]++;
      if (frame_done) begin fd_n++; fd_last = t; end
    end
    chk("mask_an0_low", 32'(lo[0]), 32'd0);
    chk("mask_an2_low", 32'(lo[2]), 32'd0);
    chk("mask_an1_low", 32'(lo[1]), 32'(RD - BLE));
    chk("mask_an3_low", 32'(lo[3]), 32'(RD - BLE));
    chk("fd_count", 32'(fd_n), 32'd1);
    chk("fd_period", 32'(fd_last), 32'(FR));
    den = '1;

    // Full-mask frame: all-off cycles equal D*blank, each anode low RD-blank cycles.
    for (int i = 0; i < D; i++) lo[i] = 0;
    all_off = 0;
    for (int t = 1; t <= FR; t++) begin
      tick();
      for (int i = 0; i < D; i++) if (!an[i]) lo[i]++;
      if (an == '1) all_off++;
    end
    chk("all_off_cycles", 32'(all_off), 32'(D * BLE));
    chk("an0_low_cycles", 32'(lo[0]), 32'(RD - BLE));

    // Commit and write on the boundary cycle itself.
    wait_fd();
    tick_n(FR - 1);
    bus.commit = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 4'h9; bus.wr_dp = 1'b0;
    tick();
    bus.commit = 1'b0; bus.wr_en = 1'b0;
    chk("boundary_commit_busy", 32'(bus.busy), 32'd0);
    tick_n(BLE + 1);
    chk("boundary_commit_seg", 32'(seg), 32'b0010010);
    wait_fd();
    tick_n(BLE + 1);
    chk("boundary_write_hidden", 32'(seg), 32'b0010010);
    bus.commit = 1'b1; tick(); bus.commit = 1'b0;
    wait_fd();
    tick_n(BLE + 1);
    chk("later_commit_shows_9", 32'(seg), 32'b0010000);
    tick_n(4);

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
